// File: rtl/gray_pkg.sv
// Shared types and constants for the Gray-code sequence controller.
package gray_pkg;

  localparam int unsigned GrayWidthDefault = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } gray_state_e;

endpackage

// File: rtl/bin2gray.sv
// Combinational binary-to-Gray converter.
module bin2gray #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = {bin[WIDTH-1], bin[WIDTH-1:1] ^ bin[WIDTH-2:0]};

endmodule

// File: rtl/gray_seq_ctrl.sv
// Streams a bounded run of binary counts and their Gray codes under ready/valid handshaking.
// Optional macro GRAY_SEQ_DOWN_EN adds dir_i, which selects a down-counting sequence.
module gray_seq_ctrl
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GrayWidthDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] start_val_i,
  input  logic [WIDTH-1:0] last_val_i,
`ifdef GRAY_SEQ_DOWN_EN
  input  logic             dir_i,
`endif
  input  logic             out_ready_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] gray_o,
  output logic [WIDTH-1:0] bin_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  gray_state_e      state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             count_down;

`ifdef GRAY_SEQ_DOWN_EN
  logic down_q, down_d;
  assign count_down = down_q;
`else
  assign count_down = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    last_d  = last_q;
`ifdef GRAY_SEQ_DOWN_EN
    down_d  = down_q;
`endif
    // Abort outranks a same-cycle start or acceptance.
    if (abort_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_d = StRun;
            bin_d   = start_val_i;
            last_d  = last_val_i;
`ifdef GRAY_SEQ_DOWN_EN
            down_d  = dir_i;
`endif
          end
        end
        StRun: begin
          if (out_ready_i) begin
            if (bin_q == last_q) begin
              state_d = StDone;
            end else if (count_down) begin
              bin_d = bin_q - One;
            end else begin
              bin_d = bin_q + One;
            end
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      bin_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      last_q  <= last_d;
    end
  end

`ifdef GRAY_SEQ_DOWN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      down_q <= 1'b0;
    end else begin
      down_q <= down_d;
    end
  end
`endif

  bin2gray #(
    .WIDTH(WIDTH)
  ) u_bin2gray (
    .bin (bin_q),
    .gray(gray_o)
  );

  assign bin_o       = bin_q;
  assign out_valid_o = (state_q == StRun);
  assign busy_o      = (state_q == StRun);
  assign done_o      = (state_q == StDone);

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Randomised and directed bench for gray_seq_ctrl against a queue-based sequence model.
module tb_gray_seq_ctrl;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk;
  logic         rst_n;
  logic         start_v;
  logic         abort_v;
  logic [W-1:0] sv_v;
  logic [W-1:0] lv_v;
  logic         dir_v;
  logic         ready_v;
  logic         out_valid;
  logic [W-1:0] gray;
  logic [W-1:0] bin;
  logic         busy;
  logic         done;

  int n_vec;
  int n_err;

  // Model: the beats still owed, and whether the completion pulse is due this cycle.
  int q[$];
  bit done_exp;

  gray_seq_ctrl #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_v),
    .abort_i    (abort_v),
    .start_val_i(sv_v),
    .last_val_i (lv_v),
`ifdef GRAY_SEQ_DOWN_EN
    .dir_i      (dir_v),
`endif
    .out_ready_i(ready_v),
    .out_valid_o(out_valid),
    .gray_o     (gray),
    .bin_o      (bin),
    .busy_o     (busy),
    .done_o     (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int to_gray(input int v);
    return v ^ (v >> 1);
  endfunction

  function automatic void model_edge();
    int v;
    if (abort_v) begin
      q.delete();
      done_exp = 1'b0;
    end else if (done_exp) begin
      done_exp = 1'b0;
    end else if (q.size() != 0) begin
      if (ready_v) begin
        void'(q.pop_front());
        if (q.size() == 0) done_exp = 1'b1;
      end
    end else if (start_v) begin
      v = int'(sv_v);
      for (int k = 0; k < M; k++) begin
        q.push_back(v);
        if (v == int'(lv_v)) break;
        v = dir_v ? (v + M - 1) % M : (v + 1) % M;
      end
    end
  endfunction

  task automatic compare();
    chk("valid", int'(out_valid), int'(q.size() != 0));
    chk("busy", int'(busy), int'(q.size() != 0));
    chk("done", int'(done), int'(done_exp));
    if (q.size() != 0 && out_valid) begin
      chk("bin", int'(bin), q[0]);
      chk("gray", int'(gray), to_gray(q[0]));
    end
  endtask

  // Called at a falling edge: drive, let the rising edge happen, then check.
  task automatic step(input logic st, input int s, input int l, input logic ab,
                      input logic rd, input logic dr);
    start_v = st;
    sv_v    = W'(s);
    lv_v    = W'(l);
    abort_v = ab;
    ready_v = rd;
    dir_v   = dr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      if (q.size() == 0 && !done_exp) break;
      step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    end
    chk("drain_idle", int'(q.size() != 0 || done_exp), 0);
  endtask

  initial begin
    logic [3:0] g38[16];
    logic [3:0] g40[4];
    int          s, l;
    logic        dr;
    g38 = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
            4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
    g40 = '{4'b1001, 4'b1000, 4'b0000, 4'b0001};
    n_vec = 0;
    n_err = 0;
    done_exp = 1'b0;
    rst_n = 1'b0;
    start_v = 1'b0;
    abort_v = 1'b0;
    sv_v = '0;
    lv_v = '0;
    dir_v = 1'b0;
    ready_v = 1'b0;
    #3;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_gray", int'(gray), 0);
    chk("rst_bin", int'(bin), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full 0..15 run with ready held.
    step(1'b1, 0, 15, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk("seq16_valid", int'(out_valid), 1);
      chk("seq16_gray", int'(gray), int'(g38[i]));
      step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    end
    chk("seq16_done", int'(done), 1);
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    chk("seq16_done_once", int'(done), 0);
    chk("seq16_end_valid", int'(out_valid), 0);

    // Back-pressure hold at bin=5.
    step(1'b1, 4, 8, 1'b0, 1'b1, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    chk("hold_gray0", int'(gray), 4'b0111);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
      chk("hold_gray", int'(gray), 4'b0111);
      chk("hold_valid", int'(out_valid), 1);
    end
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    chk("hold_next_valid", int'(out_valid), 1);
    chk("hold_next_gray", int'(gray), 4'b0101);
    drain();

    // Wrap through all-ones.
    step(1'b1, 14, 1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_gray", int'(gray), int'(g40[i]));
      step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    end
    chk("wrap_done", int'(done), 1);
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);

    // Abort during third beat, then a single-beat sequence.
    step(1'b1, 0, 7, 1'b0, 1'b1, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    chk("abort_third_bin", int'(bin), 2);
    step(1'b1, 5, 5, 1'b1, 1'b1, 1'b0);
    chk("abort_valid", int'(out_valid), 0);
    chk("abort_done", int'(done), 0);
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    chk("abort_done_later", int'(done), 0);
    step(1'b1, 3, 3, 1'b0, 1'b0, 1'b0);
    chk("single_valid", int'(out_valid), 1);
    chk("single_gray", int'(gray), 4'b0010);
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    chk("single_done", int'(done), 1);
    chk("single_valid_drop", int'(out_valid), 0);
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-run.
    step(1'b1, 0, 15, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_gray", int'(gray), 0);
    chk("arst_bin", int'(bin), 0);
    q.delete();
    done_exp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    compare();

`ifdef GRAY_SEQ_DOWN_EN
    step(1'b1, 2, 15, 1'b0, 1'b1, 1'b1);
    chk("down_gray0", int'(gray), 4'b0011);
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    chk("down_gray1", int'(gray), 4'b0001);
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    chk("down_gray2", int'(gray), 4'b0000);
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    chk("down_gray3", int'(gray), 4'b1000);
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    chk("down_done", int'(done), 1);
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
`endif

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      s = int'($urandom_range(M - 1));
      l = ($urandom_range(3) == 0) ? s : int'($urandom_range(M - 1));
`ifdef GRAY_SEQ_DOWN_EN
      dr = 1'($urandom_range(1));
`else
      dr = 1'b0;
`endif
      step(1'($urandom_range(3) == 0), s, l, 1'($urandom_range(39) == 0),
           1'($urandom_range(9) < 7), dr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
